mano_cache_ctrl: RTL and testbench
==================================

Name: mano_cache_ctrl

Overview:
- Responder for the control path's memory handshake. Accepts level-held `cs_mem_rd` / `cs_mem_wr` requests and answers with `cache_hit`; the control path stalls while `cache_hit` is 0.
- Direct-mapped, write-through, no-write-allocate cache between the control path / data path and main memory.
- Misses and all writes are serviced through a req/ack main-memory port.

Parameters:
- ADDR_W, 12, word address width (AR width).
- DATA_W, 16, data word width.
- INDEX_W, 4, index bits; lines = 2**INDEX_W, one word per line; tag = ADDR_W-INDEX_W bits.
- CNT_W, 16, width of hit/miss counters.

Ports:
- mclk  in  1  clock, all state updates on rising edge.
- mrst  in  1  reset, synchronous, active-high.
- cs_mem_rd  in  1  read request; held high until cache_hit=1.
- cs_mem_wr  in  1  write request; held high until cache_hit=1.
- addr  in  ADDR_W  request word address (AR).
- wdata  in  DATA_W  write data (bus).
- rdata  out  DATA_W  read data; valid when cache_hit=1 and cs_mem_rd=1.
- cache_hit  out  1  request complete / no stall.
- mem_req  out  1  main-memory request.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  ADDR_W  main-memory address.
- mem_wdata  out  DATA_W  main-memory write data.
- mem_rdata  in  DATA_W  main-memory read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse from main memory.
- hit_cnt  out  CNT_W  read hits, saturating.
- miss_cnt  out  CNT_W  read misses, saturating.

Behaviour:
- Storage per line: valid bit, tag, data word. `idx = addr[INDEX_W-1:0]`, `tag = addr[ADDR_W-1:INDEX_W]`.
- `lookup_hit = valid[idx] & (tag_arr[idx]==tag)`, combinational.
- States: IDLE, RD_MISS, WR_THRU. A registered flag `done` is also kept.

Reset (mrst sampled high):
- State goes to IDLE; all valid bits cleared; done=0; counters=0.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- cache_hit=0 while mrst is high.
- Reset mid-transaction abandons it; a mem_ack arriving after reset is ignored.

cache_hit (combinational):
- IDLE and no request: 1.
- IDLE and done=1: 1.
- IDLE and cs_mem_wr=1 and done=0: 0 (every write costs a memory access).
- IDLE and cs_mem_rd=1 and done=0: equals lookup_hit.
- RD_MISS or WR_THRU: 0.

rdata:
- Combinational `data_arr[idx]`.
- Don't-care when cache_hit=0 or no read.

Transitions out of IDLE (done=0):
- If both cs_mem_wr and cs_mem_rd are high, the write has priority.
- cs_mem_wr → WR_THRU. Next edge: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata.
- cs_mem_rd & !lookup_hit → RD_MISS. Next edge: mem_req=1, mem_we=0, mem_addr=addr. miss_cnt++.
- cs_mem_rd & lookup_hit: stay IDLE; hit_cnt++.

RD_MISS:
- mem_req/mem_addr held stable until mem_ack.
- On mem_ack edge: data_arr[idx]=mem_rdata, tag_arr[idx]=tag, valid[idx]=1, mem_req=0, done=1, state IDLE.

WR_THRU:
- On mem_ack edge: if lookup_hit then data_arr[idx]=wdata (no allocate on miss).
- Same edge: mem_req=0, mem_we=0, done=1, state IDLE.

done:
- Cleared on every edge where it is 1. The completion cycle therefore lasts exactly one cycle.
- That cycle does not increment hit_cnt.

Latency:
- Read hit: 0 stall cycles.
- Read miss: cache_hit rises the cycle after the mem_ack cycle.
- Write: request at cycle n, mem_req at n+1, ack at k, cache_hit=1 at k+1.

Other rules:
- mem_ack outside RD_MISS/WR_THRU is ignored.
- addr and wdata are required stable while the request is held; change mid-stall is illegal and unchecked.
- Counters saturate at all-ones.

Test Plan:
- Reset, then hold rd addr=0x005, mem returns 0x1234 with ack 3 cycles after req → cache_hit=0 for 4 cycles (the request cycle plus the 3-cycle wait for ack), then 1 for one cycle with rdata=0x1234; miss_cnt=1, hit_cnt=0.
- Repeat rd addr=0x005 → cache_hit=1 same cycle, rdata=0x1234, no mem_req, hit_cnt=1.
- rd addr=0x015 (same index, tag differs) → miss and fill; then rd 0x005 misses again; miss_cnt=3.
- wr addr=0x015 data=0xBEEF (line resident) → mem_req/mem_we=1, mem_addr=0x015, mem_wdata=0xBEEF until ack; then rd 0x015 hits with 0xBEEF.
- wr addr=0x0A0 (not resident), then rd 0x0A0 → write goes to memory only; read misses (no allocate).
- mrst pulsed during RD_MISS, late mem_ack arrives → mem_req=0 the cycle after reset, ack ignored, valid cleared; rd 0x005 then misses.

Source files
------------

// File: rtl/mano_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller between the
// control/data path and a req/ack main-memory port. One word per line.
module mano_cache_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic              mclk,
  input  logic              mrst,
  input  logic              cs_mem_rd,
  input  logic              cs_mem_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              cache_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_done;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag_arr  [LINES];
  logic [DATA_W-1:0]   r_data_arr [LINES];
  logic                r_mem_req, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [CNT_W-1:0]    r_hit_cnt, r_miss_cnt;

  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_lookup_hit;
  logic                w_cache_hit;
  logic                w_start_wr, w_start_rd, w_hit_inc, w_fill, w_wr_done;

  assign w_idx        = addr[INDEX_W-1:0];
  assign w_tag        = addr[ADDR_W-1:INDEX_W];
  assign w_lookup_hit = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);

  always_comb begin
    w_state_nxt = r_state;
    w_cache_hit = 1'b0;
    w_start_wr  = 1'b0;
    w_start_rd  = 1'b0;
    w_hit_inc   = 1'b0;
    w_fill      = 1'b0;
    w_wr_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_done) begin
          w_cache_hit = 1'b1;
        end else if (cs_mem_wr) begin
          w_start_wr  = 1'b1;
          w_state_nxt = WR_THRU;
        end else if (cs_mem_rd) begin
          w_cache_hit = w_lookup_hit;
          if (w_lookup_hit) begin
            w_hit_inc = 1'b1;
          end else begin
            w_start_rd  = 1'b1;
            w_state_nxt = RD_MISS;
          end
        end else begin
          w_cache_hit = 1'b1;
        end
      end
      RD_MISS: begin
        if (mem_ack) begin
          w_fill      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WR_THRU: begin
        if (mem_ack) begin
          w_wr_done   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (mrst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      r_valid     <= '0;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      // done can only be set from a wait state, so this also clears it after one cycle
      r_done <= w_fill | w_wr_done;
      if (w_start_wr) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= addr;
        r_mem_wdata <= wdata;
      end
      if (w_start_rd) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= addr;
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if (w_hit_inc && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_fill | w_wr_done) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
      if (w_fill) r_valid[w_idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset: the valid bits gate every use.
  always_ff @(posedge mclk) begin
    if (w_fill) begin
      r_tag_arr[w_idx]  <= w_tag;
      r_data_arr[w_idx] <= mem_rdata;
    end else if (w_wr_done && w_lookup_hit) begin
      r_data_arr[w_idx] <= wdata;
    end
  end

  assign cache_hit = w_cache_hit & ~mrst;
  assign rdata     = r_data_arr[w_idx];
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_mano_cache_ctrl.sv
// Self-checking bench for mano_cache_ctrl: directed scenarios plus random traffic
// checked against a main-memory array and a residency map of which address each line holds.
module tb_mano_cache_ctrl;

  logic        mclk = 1'b0;
  logic        mrst;
  logic        cs_mem_rd, cs_mem_wr;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        cache_hit;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt, miss_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem_model [4096];
  bit          line_valid [16];
  logic [11:0] line_addr  [16];
  int          exp_hits, exp_misses;

  mano_cache_ctrl #(.ADDR_W(12), .DATA_W(16), .INDEX_W(4), .CNT_W(16)) dut (
    .mclk(mclk), .mrst(mrst), .cs_mem_rd(cs_mem_rd), .cs_mem_wr(cs_mem_wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .cache_hit(cache_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 mclk = ~mclk;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) line_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  // Each task starts and ends 1 time unit after a rising edge.
  task automatic do_req(input bit rd, input bit wr, input logic [11:0] a,
                        input logic [15:0] wd, input int d, input string nm);
    int  stall, reqcnt, exp_stall, idx;
    bit  hit_exp, completed;
    idx       = int'(a[3:0]);
    hit_exp   = !wr && line_valid[idx] && (line_addr[idx] == a);
    exp_stall = hit_exp ? 0 : 1 + d;
    cs_mem_rd = rd; cs_mem_wr = wr; addr = a; wdata = wd;
    reqcnt = 0; stall = 0; completed = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req === 1'b1) reqcnt++;
      mem_ack   = (mem_req === 1'b1) && (reqcnt == d);
      mem_rdata = mem_ack ? mem_model[a] : 16'($urandom);
      @(negedge mclk);
      if (mem_req === 1'b1) begin
        checks++;
        if (mem_we !== wr || mem_addr !== a || (wr && mem_wdata !== wd)) begin
          failures++;
          $display("FAIL %s mem_port: we=%0b addr=%h wdata=%h required we=%0b addr=%h wdata=%h",
                   nm, mem_we, mem_addr, mem_wdata, wr, a, wd);
        end
      end
      if (cache_hit === 1'b1) begin
        completed = 1'b1;
        break;
      end
      stall++;
      @(posedge mclk); #1;
    end
    checks++;
    if (!completed) begin
      failures++;
      $display("FAIL %s timeout: cache_hit never rose within 40 cycles", nm);
    end
    checks++;
    if (stall != exp_stall) begin
      failures++;
      $display("FAIL %s stall: got %0d cycles required %0d", nm, stall, exp_stall);
    end
    if (hit_exp) begin
      checks++;
      if (mem_req !== 1'b0) begin
        failures++;
        $display("FAIL %s hit_no_mem_req: mem_req=%b required 0", nm, mem_req);
      end
    end
    if (rd && !wr) begin
      checks++;
      if (rdata !== mem_model[a]) begin
        failures++;
        $display("FAIL %s rdata: got %h required %h", nm, rdata, mem_model[a]);
      end
    end
    if (wr) mem_model[a] = wd;
    else if (hit_exp) exp_hits++;
    else begin
      exp_misses++;
      line_valid[idx] = 1'b1;
      line_addr[idx]  = a;
    end
    @(posedge mclk); #1;
    cs_mem_rd = 1'b0; cs_mem_wr = 1'b0; mem_ack = 1'b0;
    checks++;
    if (hit_cnt !== 16'(exp_hits) || miss_cnt !== 16'(exp_misses)) begin
      failures++;
      $display("FAIL %s counters: hit=%0d miss=%0d required hit=%0d miss=%0d",
               nm, hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
  endtask

  task automatic test_reset();
    mrst = 1'b1; cs_mem_rd = 1'b0; cs_mem_wr = 1'b0; mem_ack = 1'b0;
    addr = '0; wdata = '0; mem_rdata = '0;
    repeat (3) @(posedge mclk);
    #1;
    @(negedge mclk);
    checks++;
    if (cache_hit !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 12'h0 || mem_wdata !== 16'h0 || hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: hit=%b req=%b we=%b maddr=%h mwd=%h hc=%0d mc=%0d required all 0",
               cache_hit, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt);
    end
    @(posedge mclk); #1;
    mrst = 1'b0;
    model_reset();
    @(negedge mclk);
    checks++;
    if (cache_hit !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset: cache_hit=%b required 1", cache_hit);
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_read_miss_hit();
    mem_model[12'h005] = 16'h1234;
    do_req(1'b1, 1'b0, 12'h005, 16'h0, 3, "rd_miss_005");
    do_req(1'b1, 1'b0, 12'h005, 16'h0, 3, "rd_hit_005");
  endtask

  task automatic test_conflict();
    do_req(1'b1, 1'b0, 12'h015, 16'h0, 2, "rd_conflict_015");
    do_req(1'b1, 1'b0, 12'h005, 16'h0, 1, "rd_remiss_005");
  endtask

  task automatic test_write_thru();
    do_req(1'b1, 1'b0, 12'h015, 16'h0, 2, "rd_fill_015");
    do_req(1'b0, 1'b1, 12'h015, 16'hBEEF, 2, "wr_resident_015");
    do_req(1'b1, 1'b0, 12'h015, 16'h0, 2, "rd_after_wr_015");
  endtask

  task automatic test_write_no_alloc();
    do_req(1'b0, 1'b1, 12'h0A0, 16'hCAFE, 1, "wr_nonres_0A0");
    do_req(1'b1, 1'b0, 12'h0A0, 16'h0, 2, "rd_after_wr_0A0");
  endtask

  task automatic test_wr_priority();
    do_req(1'b1, 1'b1, 12'h0A0, 16'h5A5A, 2, "rdwr_priority_0A0");
    do_req(1'b1, 1'b0, 12'h0A0, 16'h0, 1, "rd_after_prio_0A0");
  endtask

  task automatic test_reset_mid_txn();
    do_req(1'b1, 1'b0, 12'h005, 16'h0, 1, "rd_pre_reset_005");
    cs_mem_rd = 1'b1; addr = 12'h033;
    @(posedge mclk); #1;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_req: mem_req=%b required 1", mem_req);
    end
    mrst = 1'b1;
    @(negedge mclk);
    checks++;
    if (cache_hit !== 1'b0) begin
      failures++;
      $display("FAIL hit_during_reset: cache_hit=%b required 0", cache_hit);
    end
    @(posedge mclk); #1;
    mrst = 1'b0; cs_mem_rd = 1'b0;
    model_reset();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL req_after_reset: mem_req=%b required 0", mem_req);
    end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge mclk);
    checks++;
    if (cache_hit !== 1'b1) begin
      failures++;
      $display("FAIL late_ack_idle: cache_hit=%b required 1", cache_hit);
    end
    @(posedge mclk); #1;
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || miss_cnt !== 16'h0 || hit_cnt !== 16'h0) begin
      failures++;
      $display("FAIL late_ack_ignored: req=%b miss=%0d hit=%0d required 0/0/0",
               mem_req, miss_cnt, hit_cnt);
    end
    do_req(1'b1, 1'b0, 12'h005, 16'h0, 2, "rd_post_reset_005");
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      logic [11:0] a;
      int op, d;
      a  = {6'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      op = $urandom_range(0, 9);
      d  = $urandom_range(1, 4);
      if (op < 6)      do_req(1'b1, 1'b0, a, 16'h0, d, "rand_rd");
      else if (op < 9) do_req(1'b0, 1'b1, a, 16'($urandom), d, "rand_wr");
      else             do_req(1'b1, 1'b1, a, 16'($urandom), d, "rand_rdwr");
      if ($urandom_range(0, 4) == 0) begin
        @(negedge mclk);
        checks++;
        if (cache_hit !== 1'b1) begin
          failures++;
          $display("FAIL rand_idle: cache_hit=%b required 1", cache_hit);
        end
        @(posedge mclk); #1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = 16'($urandom);
    model_reset();
    test_reset();
    test_read_miss_hit();
    test_conflict();
    test_write_thru();
    test_write_no_alloc();
    test_wr_priority();
    test_reset_mid_txn();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
